ctr_keystream_reader: RTL

- Consumer end of the AES-256-CTR keystream batch interface.
- Accepts 512-bit keystream batches from the 4-core CTR generator. Each batch holds 4 AES blocks of 16 bytes.
- Buffers up to two batches and serialises them into 32-bit words on a valid/ready stream for the downstream sampler/XOR logic.
- Counts blocks against the XOF or PRF target and signals end of session.

---
 rtl/ctr_keystream_reader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/ctr_keystream_reader.sv
// Consumer side of the AES-256-CTR keystream batch interface: buffers up to two
// 512-bit batches and serialises them MSB-first into 32-bit valid/ready words.
module ctr_keystream_reader #(
    parameter int BATCH_BYTES       = 64,
    parameter int BLOCK_BYTES       = 16,
    parameter int WORD_BITS         = 32,
    parameter int XOF_TARGET_BLOCKS = 44,
    parameter int PRF_TARGET_BLOCKS = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [BATCH_BYTES*8-1:0] batch_in,
    input  logic                     batch_valid,
    output logic                     batch_ready,
    output logic [WORD_BITS-1:0]     word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     word_last,
    output logic                     done,
    output logic                     overflow_err,
    output logic [5:0]               blocks_rcvd
);

    localparam int BATCH_BITS       = BATCH_BYTES * 8;
    localparam int BLOCKS_PER_BATCH = BATCH_BYTES / BLOCK_BYTES;
    localparam int WORDS_PER_BATCH  = BATCH_BITS / WORD_BITS;
    localparam int W_W              = $clog2(WORDS_PER_BATCH);
    localparam int SEL_W            = $clog2(BATCH_BITS);
    localparam int CNT_W            = 4;

    localparam logic [CNT_W-1:0] XOF_BATCHES = CNT_W'(XOF_TARGET_BLOCKS / BLOCKS_PER_BATCH);
    localparam logic [CNT_W-1:0] PRF_BATCHES = CNT_W'(PRF_TARGET_BLOCKS / BLOCKS_PER_BATCH);
    localparam logic [W_W-1:0]   LAST_W      = W_W'(WORDS_PER_BATCH - 1);
    localparam logic [5:0]       BLOCK_INC   = 6'(BLOCKS_PER_BATCH);

    // Session targets must be whole batches, otherwise the batch counter never lands on them.
    generate
        if ((XOF_TARGET_BLOCKS % BLOCKS_PER_BATCH) != 0 ||
            (PRF_TARGET_BLOCKS % BLOCKS_PER_BATCH) != 0) begin : g_target_check
            $error("ctr_keystream_reader: block targets must be multiples of blocks per batch");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [BATCH_BITS-1:0]  buf_q [2];
    logic [BATCH_BITS-1:0]  buf_d [2];
    logic                   head_q, head_d;
    logic [1:0]             entries_q, entries_d;
    logic [W_W-1:0]         w_q, w_d;
    logic [CNT_W-1:0]       batch_cnt_q, batch_cnt_d;
    logic [CNT_W-1:0]       pop_cnt_q, pop_cnt_d;
    logic [5:0]             blocks_q, blocks_d;
    logic                   overflow_q, overflow_d;

    logic [CNT_W-1:0]       target;
    logic                   tail;
    logic                   push;
    logic                   hs;
    logic                   pop;
    logic [W_W-1:0]         word_idx;
    logic [SEL_W-1:0]       word_lsb;
    logic [BATCH_BITS-1:0]  head_batch;

    assign target      = mode_q ? PRF_BATCHES : XOF_BATCHES;
    assign batch_ready = (state_q == S_RUN) && (entries_q != 2'd2);
    assign word_valid  = (entries_q != 2'd0);
    assign head_batch  = buf_q[head_q];
    assign word_idx    = LAST_W - w_q;
    assign word_lsb    = SEL_W'(word_idx) * SEL_W'(WORD_BITS);
    assign word_out    = word_valid ? head_batch[word_lsb +: WORD_BITS] : '0;
    // The head is the final batch once all earlier batches of the session have been popped.
    assign word_last   = word_valid && (w_q == LAST_W) && (pop_cnt_q == target - CNT_W'(1));
    assign push        = batch_valid && batch_ready;
    assign hs          = word_valid && word_ready;
    assign pop         = hs && (w_q == LAST_W);
    assign tail        = head_q ^ (entries_q == 2'd1);

    assign done         = (state_q == S_DONE);
    assign overflow_err = overflow_q;
    assign blocks_rcvd  = blocks_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        buf_d       = buf_q;
        head_d      = head_q;
        entries_d   = entries_q + 2'(push) - 2'(pop);
        w_d         = w_q;
        batch_cnt_d = batch_cnt_q;
        pop_cnt_d   = pop_cnt_q;
        blocks_d    = blocks_q;
        overflow_d  = overflow_q;

        if (push) begin
            buf_d[tail] = batch_in;
            batch_cnt_d = batch_cnt_q + CNT_W'(1);
            blocks_d    = blocks_q + BLOCK_INC;
        end

        if (hs) begin
            if (w_q == LAST_W) begin
                w_d       = '0;
                head_d    = ~head_q;
                pop_cnt_d = pop_cnt_q + CNT_W'(1);
            end else begin
                w_d = w_q + W_W'(1);
            end
        end

        if (batch_valid && !batch_ready && (state_q == S_RUN || state_q == S_DRAIN)) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RUN;
                    mode_d      = mode;
                    head_d      = 1'b0;
                    entries_d   = 2'd0;
                    w_d         = '0;
                    batch_cnt_d = '0;
                    pop_cnt_d   = '0;
                    blocks_d    = '0;
                    overflow_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (push && (batch_cnt_q + CNT_W'(1) == target)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hs && word_last) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            head_q      <= 1'b0;
            entries_q   <= 2'd0;
            w_q         <= '0;
            batch_cnt_q <= '0;
            pop_cnt_q   <= '0;
            blocks_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            buf_q       <= buf_d;
            head_q      <= head_d;
            entries_q   <= entries_d;
            w_q         <= w_d;
            batch_cnt_q <= batch_cnt_d;
            pop_cnt_q   <= pop_cnt_d;
            blocks_q    <= blocks_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule
